ones_index_enum: RTL and testbench



---
 rtl/ones_index_enum.sv | 101 ++++++++++
 tb/tb_ones_index_enum.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ones_index_enum.sv
// Walks a mask and emits the index of each set bit, LSB-first, one beat per cycle.
// Latency: first beat is valid the cycle after accept; back-to-back masks have no bubble.
// Backpressure: out_ready low freezes every out_* signal and holds in_ready low.

module ones_index_enum_popcount #(
   parameter  int W  = 8,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] cnt
);
   generate
      if (W == 1) begin : g_leaf
         assign cnt = bits;
      end else begin : g_split
         localparam int LW = W / 2;
         localparam int HW = W - LW;
         logic [$clog2(LW + 1)-1:0] lo_cnt;
         logic [$clog2(HW + 1)-1:0] hi_cnt;

         ones_index_enum_popcount #(.W(LW)) u_lo (.bits(bits[LW-1:0]), .cnt(lo_cnt));
         ones_index_enum_popcount #(.W(HW)) u_hi (.bits(bits[W-1:LW]), .cnt(hi_cnt));

         assign cnt = CW'(lo_cnt) + CW'(hi_cnt);
      end
   endgenerate
endmodule

module ones_index_enum #(
   parameter  int DATA_WIDTH = 8,
   localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
   localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IDX_W-1:0]      out_idx,
   output logic [CNT_W-1:0]      out_seq,
   output logic [CNT_W-1:0]      out_total,
   output logic                  out_last,
   output logic                  out_none
);
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] rem;
   logic [DATA_WIDTH-1:0] rem_clr;
   logic [CNT_W-1:0]      seq;
   logic [CNT_W-1:0]      total;
   logic [CNT_W-1:0]      mask_cnt;
   logic [IDX_W-1:0]      low_idx;
   logic                  rem_single;
   logic                  beat;
   logic                  accept;

   ones_index_enum_popcount #(.W(DATA_WIDTH)) u_mask_cnt (.bits(in_mask), .cnt(mask_cnt));

   always_comb begin
      low_idx = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (rem[i]) low_idx = IDX_W'(i);
      end
   end

   // rem & (rem-1) drops the lowest set bit; zero result means at most one bit was left
   assign rem_clr    = rem & (rem - DATA_WIDTH'(1));
   assign rem_single = (rem_clr == '0);

   assign out_valid = (state == EMIT);
   assign beat      = out_valid && out_ready;
   assign in_ready  = (state == IDLE) || (beat && rem_single);
   assign accept    = in_valid && in_ready;

   assign out_idx   = out_valid ? low_idx : '0;
   assign out_seq   = out_valid ? seq : '0;
   assign out_total = out_valid ? total : '0;
   assign out_last  = out_valid && rem_single;
   assign out_none  = out_valid && (rem == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rem   <= '0;
         seq   <= '0;
         total <= '0;
      end else if (accept) begin
         state <= EMIT;
         rem   <= in_mask;
         seq   <= '0;
         total <= mask_cnt;
      end else if (beat) begin
         rem <= rem_clr;
         seq <= seq + CNT_W'(1);
         if (rem_single) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_ones_index_enum.sv
// Checks ones_index_enum against a queue-of-beats model: table vectors, hand corner sequences, random traffic.
module tb_ones_index_enum;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_mask;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic [3:0] out_seq;
   logic [3:0] out_total;
   logic       out_last;
   logic       out_none;

   ones_index_enum #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_seq(out_seq), .out_total(out_total),
      .out_last(out_last), .out_none(out_none)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] idx;
      logic [3:0] seq;
      logic [3:0] total;
      logic       last;
      logic       none;
   } beat_t;

   typedef struct {
      logic [7:0] mask;
      int         total;
      int         first;
      int         last;
      int         beats;
   } vec_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   logic  prev_stall = 1'b0;
   beat_t prev_outs;
   logic  s_in_ready;
   int    beat_cnt, first_idx, last_idx, last_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_mask(input logic [7:0] m);
      int tot = 0;
      int s   = 0;
      beat_t b;
      for (int i = 0; i < 8; i++) tot += m[i];
      if (tot == 0) begin
         b = '{idx: 3'd0, seq: 4'd0, total: 4'd0, last: 1'b1, none: 1'b1};
         exp_q.push_back(b);
      end
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            b = '{idx: 3'(i), seq: 4'(s), total: 4'(tot), last: (s == tot - 1), none: 1'b0};
            exp_q.push_back(b);
            s++;
         end
      end
   endtask

   // One clock cycle: sample at negedge, score, then return just after the next rising edge.
   task automatic step();
      beat_t cur, e;
      logic  exp_rdy;
      @(negedge clk);
      cur        = {out_idx, out_seq, out_total, out_last, out_none};
      s_in_ready = in_ready;
      exp_rdy    = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_rdy);
      if (prev_stall) check("stall_hold", cur, prev_outs);
      if (!out_valid) check("gated_outs", cur, 0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("beat", cur, e);
         beat_cnt++;
         if (out_seq == 0) first_idx = out_idx;
         if (out_last) begin
            last_idx   = out_idx;
            last_total = out_total;
         end
      end
      if (in_valid && in_ready) push_mask(in_mask);
      prev_stall = out_valid && !out_ready;
      prev_outs  = cur;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("reset_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_outs", {out_idx, out_seq, out_total, out_last, out_none}, 0);
      exp_q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while (exp_q.size() != 0 && guard < 40) begin
         step();
         guard++;
      end
      if (guard >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: %0d beats still pending, expected 0", name, exp_q.size());
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{mask: 8'hA4, total: 3, first: 2, last: 7, beats: 3};
      vecs[1] = '{mask: 8'h00, total: 0, first: 0, last: 0, beats: 1};
      vecs[2] = '{mask: 8'hFF, total: 8, first: 0, last: 7, beats: 8};
      vecs[3] = '{mask: 8'h01, total: 1, first: 0, last: 0, beats: 1};
      vecs[4] = '{mask: 8'h80, total: 1, first: 7, last: 7, beats: 1};
      vecs[5] = '{mask: 8'h5A, total: 4, first: 1, last: 6, beats: 4};

      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_mask   = '0;
      out_ready = 1'b1;
      do_reset();

      // Isolated masks with the consumer always ready
      for (int v = 0; v < 6; v++) begin
         beat_cnt = 0; first_idx = -1; last_idx = -1; last_total = -1;
         in_mask   = vecs[v].mask;
         in_valid  = 1'b1;
         out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         drain("vec");
         check("vec_beats", beat_cnt, vecs[v].beats);
         check("vec_first_idx", first_idx, vecs[v].first);
         check("vec_last_idx", last_idx, vecs[v].last);
         check("vec_total", last_total, vecs[v].total);
         step();
      end

      // All-ones mask with the consumer ready every other cycle
      in_mask  = 8'hFF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat_cnt = 0;
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         out_ready = (c % 2 == 0);
         step();
      end
      check("bp_beats", beat_cnt, 8);
      check("bp_pending", exp_q.size(), 0);
      out_ready = 1'b1;
      step();

      // Back-to-back: second mask accepted on the first mask's last beat
      in_mask  = 8'h01;
      in_valid = 1'b1;
      step();
      in_mask = 8'h80;
      step();
      check("b2b_in_ready", s_in_ready, 1);
      in_valid = 1'b0;
      beat_cnt = 0;
      step();
      check("b2b_beats", beat_cnt, 1);
      check("b2b_idx", last_idx, 7);
      step();

      // Reset while beats remain
      in_mask  = 8'hF0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat_cnt = 0;
      step();
      step();
      check("mid_beats_before_reset", beat_cnt, 2);
      do_reset();
      beat_cnt = 0; last_idx = -1;
      in_mask  = 8'h02;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      drain("post_reset");
      step();
      check("post_reset_beats", beat_cnt, 1);
      check("post_reset_idx", last_idx, 1);

      // Random traffic against the queue model
      for (int c = 0; c < 500; c++) begin
         int r;
         r         = $urandom_range(0, 9);
         in_valid  = ($urandom_range(0, 1) == 1);
         in_mask   = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom());
         out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("random");
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
